// File: rtl/event_sequencer.sv
// event_sequencer: round-robin arbiter that turns event requests into a one-hot
// trigger bus, with pairwise event aliasing and an in-line in-order checker.
module event_sequencer #(
    parameter int N_EVT = 3,
    parameter int IDX_W = 2,
    parameter int TMO   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EVT-1:0] req,
    output logic [N_EVT-1:0] ack,
    output logic [N_EVT-1:0] evt_trig,
    input  logic             merge_wr,
    input  logic [IDX_W-1:0] merge_a,
    input  logic [IDX_W-1:0] merge_b,
    output logic             seq_done,
    output logic             seq_fail,
    output logic [IDX_W-1:0] exp_idx,
    output logic             busy
);
    localparam int             TW      = $clog2(TMO + 1);
    localparam logic [IDX_W:0] N_EVT_C = (IDX_W + 1)'(N_EVT);

    function automatic logic [IDX_W:0] popcount(input logic [N_EVT-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N_EVT; i++) begin
            c = c + (IDX_W + 1)'(v[i]);
        end
        return c;
    endfunction

    logic [N_EVT-1:0][N_EVT-1:0] grp;
    logic [IDX_W-1:0]            ptr;
    logic [TW-1:0]               tmo_cnt;

    logic [N_EVT-1:0] elig_p0;
    logic [N_EVT-1:0] trig_p0;
    logic [IDX_W-1:0] gnt_p0;
    logic [IDX_W-1:0] hi_g;
    logic [IDX_W-1:0] lo_g;
    logic             hi_found;
    logic             vld_p0;

    // Stage 0: round-robin pick among requesters not acked last cycle
    assign elig_p0 = req & ~ack;

    always_comb begin
        hi_found = 1'b0;
        hi_g     = '0;
        lo_g     = '0;
        vld_p0   = 1'b0;
        // Descending scan leaves the lowest eligible index at/after ptr in hi_g
        // and the lowest eligible index overall in lo_g (the wrap-around case).
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (elig_p0[i]) begin
                vld_p0 = 1'b1;
                lo_g   = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_g     = IDX_W'(i);
                end
            end
        end
        gnt_p0 = hi_found ? hi_g : lo_g;
    end

    assign trig_p0 = (N_EVT'(1) << gnt_p0) | grp[gnt_p0];

    // Stage 1: registered grant, trigger, pointer and merge table
    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= '0;
            evt_trig <= '0;
            ptr      <= '0;
            grp      <= '0;
        end else begin
            ack      <= vld_p0 ? (N_EVT'(1) << gnt_p0) : '0;
            evt_trig <= vld_p0 ? trig_p0 : '0;
            if (vld_p0) begin
                ptr <= (int'(gnt_p0) == N_EVT - 1) ? '0 : gnt_p0 + 1'b1;
            end
            if (merge_wr && (merge_a != merge_b) &&
                ({1'b0, merge_a} < N_EVT_C) && ({1'b0, merge_b} < N_EVT_C)) begin
                grp[merge_a][merge_b] <= 1'b1;
                grp[merge_b][merge_a] <= 1'b1;
            end
        end
    end

    logic [N_EVT-1:0] fp_p1;
    logic [N_EVT-1:0] sh_p1;
    logic [IDX_W:0]   sum_p1;
    logic             adv_p1;

    // Drop already-seen events; remaining bits must start at exp_idx and be contiguous
    assign fp_p1  = evt_trig & ~((N_EVT'(1) << exp_idx) - N_EVT'(1));
    assign sh_p1  = fp_p1 >> exp_idx;
    assign adv_p1 = sh_p1[0] && ((sh_p1 & (sh_p1 + N_EVT'(1))) == '0);
    assign sum_p1 = {1'b0, exp_idx} + popcount(fp_p1);
    assign busy   = (exp_idx != '0);

    // Stage 2: order checker and idle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_idx  <= '0;
            tmo_cnt  <= '0;
            seq_done <= 1'b0;
            seq_fail <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            seq_fail <= 1'b0;
            if (fp_p1 != '0) begin
                tmo_cnt <= '0;
                if (!adv_p1) begin
                    seq_fail <= 1'b1;
                    exp_idx  <= '0;
                end else if (sum_p1 == N_EVT_C) begin
                    seq_done <= 1'b1;
                    exp_idx  <= '0;
                end else begin
                    exp_idx <= sum_p1[IDX_W-1:0];
                end
            end else if (busy) begin
                if (tmo_cnt == TW'(TMO - 1)) begin
                    seq_fail <= 1'b1;
                    exp_idx  <= '0;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_event_sequencer.sv
// Bench for event_sequencer: directed test-plan steps plus random traffic,
// every cycle compared against an event-level reference model.
module tb_event_sequencer;
    localparam int N   = 3;
    localparam int IW  = 2;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [N-1:0]  evt_trig;
    logic          merge_wr;
    logic [IW-1:0] merge_a;
    logic [IW-1:0] merge_b;
    logic          seq_done;
    logic          seq_fail;
    logic [IW-1:0] exp_idx;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_ack;
    logic [N-1:0] m_trig;
    logic         m_done;
    logic         m_fail;
    int           m_exp;
    int           m_ptr;
    int           m_tmo;
    logic [63:0]  m_grp;

    always #5 clk = ~clk;

    event_sequencer #(.N_EVT(N), .IDX_W(IW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .evt_trig(evt_trig),
        .merge_wr(merge_wr), .merge_a(merge_a), .merge_b(merge_b),
        .seq_done(seq_done), .seq_fail(seq_fail), .exp_idx(exp_idx), .busy(busy)
    );

    function automatic bit has(input logic [63:0] v, input int i);
        return ((v >> i) & 64'd1) == 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: predict from current inputs and model state, clock, compare all outputs.
    task automatic tick();
        logic [N-1:0] n_ack;
        logic [N-1:0] n_trig;
        logic         n_done;
        logic         n_fail;
        int           n_exp;
        int           n_tmo;
        int           n_ptr;
        int           cnt;
        int           g;
        int           c;
        bit           ok;
        n_ack  = '0;
        n_trig = '0;
        n_done = 1'b0;
        n_fail = 1'b0;
        n_exp  = m_exp;
        n_tmo  = m_tmo;
        n_ptr  = m_ptr;
        if (rst) begin
            n_exp = 0;
            n_tmo = 0;
            n_ptr = 0;
            m_grp = '0;
        end else begin
            cnt = 0;
            ok  = 1'b1;
            for (int i = m_exp; i < N; i++) begin
                if (has(64'(m_trig), i)) begin
                    if (i != m_exp + cnt) ok = 1'b0;
                    cnt++;
                end
            end
            if (cnt == 0) begin
                if (m_exp != 0) begin
                    n_tmo = m_tmo + 1;
                    if (n_tmo == TMO) begin
                        n_fail = 1'b1;
                        n_exp  = 0;
                        n_tmo  = 0;
                    end
                end else begin
                    n_tmo = 0;
                end
            end else if (ok) begin
                n_tmo = 0;
                n_exp = m_exp + cnt;
                if (n_exp == N) begin
                    n_done = 1'b1;
                    n_exp  = 0;
                end
            end else begin
                n_fail = 1'b1;
                n_exp  = 0;
                n_tmo  = 0;
            end
            g = -1;
            for (int off = 0; off < N; off++) begin
                c = (m_ptr + off) % N;
                if (g < 0 && has(64'(req), c) && !has(64'(m_ack), c)) g = c;
            end
            if (g >= 0) begin
                n_ack  = N'(1) << g;
                n_trig = (N'(1) << g) | N'(m_grp >> (g * 8));
                n_ptr  = (g + 1) % N;
            end
            if (merge_wr && merge_a != merge_b && int'(merge_a) < N && int'(merge_b) < N) begin
                m_grp = m_grp | (64'd1 << (int'(merge_a) * 8 + int'(merge_b)))
                              | (64'd1 << (int'(merge_b) * 8 + int'(merge_a)));
            end
        end
        @(posedge clk);
        #1;
        m_ack  = n_ack;
        m_trig = n_trig;
        m_done = n_done;
        m_fail = n_fail;
        m_exp  = n_exp;
        m_tmo  = n_tmo;
        m_ptr  = n_ptr;
        chk("ack", 32'(ack), 32'(m_ack));
        chk("evt_trig", 32'(evt_trig), 32'(m_trig));
        chk("seq_done", 32'(seq_done), 32'(m_done));
        chk("seq_fail", 32'(seq_fail), 32'(m_fail));
        chk("exp_idx", 32'(exp_idx), 32'(m_exp));
        chk("busy", 32'(busy), 32'(m_exp != 0));
    endtask

    task automatic pulse(input logic [N-1:0] v);
        req = v;
        tick();
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; merge_wr = 1'b0; merge_a = '0; merge_b = '0;
        m_ack = '0; m_trig = '0; m_done = 1'b0; m_fail = 1'b0;
        m_exp = 0; m_ptr = 0; m_tmo = 0; m_grp = '0;
        tick();
        tick();
        chk("rst_trig", 32'(evt_trig), 32'd0);
        chk("rst_exp", 32'(exp_idx), 32'd0);
        rst = 1'b0;

        // In-order sequence
        pulse(3'b001);
        chk("t1_trig0", 32'(evt_trig), 32'b001);
        pulse(3'b010);
        chk("t1_trig1", 32'(evt_trig), 32'b010);
        chk("t1_exp1", 32'(exp_idx), 32'd1);
        pulse(3'b100);
        chk("t1_trig2", 32'(evt_trig), 32'b100);
        chk("t1_exp2", 32'(exp_idx), 32'd2);
        tick();
        chk("t1_done", 32'(seq_done), 32'd1);
        chk("t1_exp0", 32'(exp_idx), 32'd0);
        chk("t1_nofail", 32'(seq_fail), 32'd0);

        // Out of order start
        pulse(3'b010);
        chk("t2_trig", 32'(evt_trig), 32'b010);
        tick();
        chk("t2_fail", 32'(seq_fail), 32'd1);
        chk("t2_exp", 32'(exp_idx), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // Contention from pointer 0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b111; tick();
        chk("t3_ack0", 32'(ack), 32'b001);
        req = 3'b110; tick();
        chk("t3_ack1", 32'(ack), 32'b010);
        req = 3'b100; tick();
        chk("t3_ack2", 32'(ack), 32'b100);
        req = 3'b000; tick();
        chk("t3_done", 32'(seq_done), 32'd1);
        req = 3'b011; tick();
        chk("t3_ptr0", 32'(ack), 32'b001);
        req = 3'b010; tick();
        chk("t3_ptr1", 32'(ack), 32'b010);
        req = 3'b000; tick();
        rst = 1'b1; tick(); rst = 1'b0;

        // Idle timeout
        pulse(3'b001);
        tick();
        chk("t5_exp1", 32'(exp_idx), 32'd1);
        for (int i = 1; i <= TMO; i++) begin
            tick();
            chk("t5_fail", 32'(seq_fail), 32'(i == TMO));
        end
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_exp0", 32'(exp_idx), 32'd0);

        // Merge 0/1
        merge_wr = 1'b1; merge_a = 2'd0; merge_b = 2'd1; tick(); merge_wr = 1'b0;
        pulse(3'b001);
        chk("t4_trig", 32'(evt_trig), 32'b011);
        tick();
        chk("t4_exp", 32'(exp_idx), 32'd2);
        pulse(3'b100);
        tick();
        chk("t4_done", 32'(seq_done), 32'd1);
        pulse(3'b010);
        chk("t4_trig_b", 32'(evt_trig), 32'b011);
        tick();
        chk("t4_exp_b", 32'(exp_idx), 32'd2);
        pulse(3'b100);
        tick();
        chk("t4_done_b", 32'(seq_done), 32'd1);

        // Reset mid-sequence, also overriding a merge write
        pulse(3'b001);
        tick();
        rst = 1'b1; merge_wr = 1'b1; merge_a = 2'd0; merge_b = 2'd2;
        tick();
        rst = 1'b0; merge_wr = 1'b0;
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_trig", 32'(evt_trig), 32'd0);
        chk("t6_exp", 32'(exp_idx), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        pulse(3'b010);
        chk("t6_trig2", 32'(evt_trig), 32'b010);
        tick();
        chk("t6_fail", 32'(seq_fail), 32'd1);
        pulse(3'b001);
        chk("t6_nomerge02", 32'(evt_trig), 32'b001);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = N'($urandom_range(0, 7));
                default: req = N'(1) << m_exp;
            endcase
            merge_wr = ($urandom_range(0, 15) == 0);
            merge_a  = IW'($urandom_range(0, 3));
            merge_b  = IW'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0; req = '0; merge_wr = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/event_sequencer.md
# event_sequencer

Synthesizable event scheduler and order checker for the threads/IPC test infrastructure. Up to `N_EVT` requesters each ask to fire a named event. A round-robin arbiter serialises the requests onto a one-hot trigger bus, one grant per cycle. A merge table lets two events alias, so firing either fires both. An in-line checker confirms the events arrive in index order 0 → N_EVT-1 and reports pass, fail or timeout.

## Interface
- `N_EVT`, default 3: number of events/requesters (2..8).
- `IDX_W`, default 2: index width, equal to clog2(N_EVT).
- `TMO`, default 16: maximum idle cycles between consecutive in-order events while a sequence is in progress.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_EVT: level request per event. Held until the matching `ack`, dropped the next cycle.
- `ack` out N_EVT: one-cycle grant pulse, at most one bit set.
- `evt_trig` out N_EVT: one-cycle trigger vector. The granted bit OR its merged partners.
- `merge_wr` in 1: write strobe for the merge table.
- `merge_a`, `merge_b` in IDX_W each: the pair of events to merge.
- `seq_done` out 1: one-cycle pulse, full ordered sequence seen.
- `seq_fail` out 1: one-cycle pulse, order violation or timeout.
- `exp_idx` out IDX_W: next expected event index.
- `busy` out 1: sequence in progress (`exp_idx != 0`).

## Operation

Reset. When `rst` is sampled high:
- `ack`, `evt_trig`, `seq_done`, `seq_fail`, `exp_idx` and `busy` all go to 0.
- The merge matrix `grp` is cleared.
- The round-robin pointer and the timeout counter go to 0.
- Reset has priority over every other input, including mid-sequence and during `merge_wr`.

Arbiter:
- Eligible requesters are `req` AND NOT(previous-cycle `ack`). This masks a requester during the cycle in which it drops `req`.
- Round-robin search starts at the pointer. The winner `g` gets `ack[g]`, and the pointer moves to `g+1`, wrapping modulo N_EVT.
- When no requester is eligible, `ack` and `evt_trig` are 0 and the pointer holds.

Merge table:
- On `merge_wr` with `merge_a != merge_b`, set `grp[a][b]` and `grp[b][a]`.
- `merge_a == merge_b`, or an out-of-range index, is ignored.
- Merges are not transitive and are cleared only by reset.

Trigger expansion:
- `F = onehot(g) | grp[g]`, and `evt_trig = F`.

Order checker. Let `F'` be `F` with all bits below `exp_idx` removed.
- `F'` is empty (a repeat of an already-seen event): ignored. No state change, timeout counter keeps running.
- The lowest bit of `F'` equals `exp_idx` and the bits of `F'` are contiguous from it: advance `exp_idx` by popcount(`F'`) and clear the timeout counter.
- If that advance reaches N_EVT: pulse `seq_done` and set `exp_idx` to 0.
- Any other `F'`: pulse `seq_fail`, set `exp_idx` to 0 and clear the timeout counter.

Timeout:
- While `busy`, count cycles with no advance.
- When the count reaches `TMO`: pulse `seq_fail`, set `exp_idx` to 0 and clear the counter.
- Not busy: the counter holds at 0.

## Timing
- `req[i]` high at rising edge k: `ack[i]` and `evt_trig` are high for the cycle after edge k. This is a registered output, 1-cycle latency.
- `seq_done`, `seq_fail`, `exp_idx` and `busy` update one cycle after the `evt_trig` cycle. Checker latency is 2 cycles from the `req` edge.
- Arbiter throughput is one grant per cycle. A given requester is granted at most once every 2 cycles because of the ack mask.
- `merge_wr` at edge k affects grants made at edge k+1 onward. A grant at edge k uses the old table.
- A timeout and an advance in the same cycle: the advance wins.
- A fail and a done in the same cycle cannot occur. `seq_done` and `seq_fail` are mutually exclusive.

## Test plan
1. **In order.** `N_EVT=3`. Pulse `req` 001, then 010, then 100, each dropped after its ack. Required:
   - `evt_trig` shows 001, 010, 100.
   - `exp_idx` steps 1, 2, 0.
   - `seq_done` pulses once, one cycle after `evt_trig=100`.
   - `seq_fail` stays 0.
2. **Out of order.** First request is `req=010`. Required: `evt_trig=010`, `seq_fail` pulses 1 cycle later, `exp_idx` stays 0, `busy` stays 0.
3. **Contention.** Pointer at 0, `req=111`, each requester drops its bit after its ack. Required:
   - Acks arrive in order 001, 010, 100 on consecutive cycles.
   - `seq_done` pulses.
   - The pointer returns to 0.
4. **Merge.** `merge_wr` with a=0, b=1, then `req=001`. Required:
   - `evt_trig=011` and `exp_idx` goes to 2.
   - Then `req=100` gives `seq_done`.
   - Repeat with `req=010` first: also `evt_trig=011`, advance to 2.
5. **Timeout.** `req=001` acked, then no requests. Required: `seq_fail` pulses on idle cycle 16, after which `busy=0` and `exp_idx=0`.
6. **Reset mid-sequence.** After the `001` event plus the 0/1 merge, assert `rst` for 1 cycle. Required:
   - All outputs are 0.
   - A following `req=010` gives `evt_trig=010`, with no merge, and `seq_fail` pulses.
